crossing_scheduler: RTL and testbench

- Sequencer for the cat/dog/mouse river-crossing game.
- Accepts debounced button pulses, arbitrates and validates move requests, and steps the crossing animation on a 4 Hz tick.
- Updates bank positions and the BCD move counter, and evaluates win/lose.
- Its outputs feed the LED-matrix, LED-bar and seven-segment display logic.

---
 rtl/crossing_scheduler.sv | 123 ++++++++++++
 tb/tb_crossing_scheduler.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/crossing_scheduler.sv
// crossing_scheduler: arbitrates cat/dog/mouse/canoe requests, animates the crossing on tick_4Hz and scores the game.
// Optional MOVE_LIMIT_EN adds a MAX_MOVES loss condition.
module crossing_scheduler #(
  parameter int STEPS = 16,
  parameter int PASS_SHIFT = 2
`ifdef MOVE_LIMIT_EN
  , parameter int MAX_MOVES = 17
`endif
) (
  input  logic       clk_1kHz,
  input  logic       rst_n,
  input  logic       tick_4Hz,
  input  logic       sw6,
  input  logic [3:0] req,
  input  logic       clr,
  output logic       cat_position,
  output logic       dog_position,
  output logic       mouse_position,
  output logic       canoe_position,
  output logic [2:0] passenger,
  output logic [1:0] pass_col,
  output logic [3:0] cnt_canoe,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic [1:0] gameState,
  output logic       reject
);
  localparam logic [3:0] LAST = 4'(STEPS - 1);
`ifdef MOVE_LIMIT_EN
  localparam logic [7:0] LIMIT = {4'(MAX_MOVES / 10), 4'(MAX_MOVES % 10)};
`endif
  typedef enum logic [2:0] {IDLE, CROSS, CHECK, WIN, LOSE} state_t;
  state_t state;
  logic [3:0] step, step_nx, cnt_nx, ones_nx, tens_nx;
  logic dir, pick_ok, win_c, lose_c;
  logic [2:0] pick;
  always_comb begin
    step_nx = step + 4'd1;
    cnt_nx = dir ? step_nx : LAST - step_nx;
    pick = req[3] ? 3'b100 : req[2] ? 3'b010 : req[1] ? 3'b001 : 3'b000;
    pick_ok = req[3] ? cat_position == canoe_position :
              req[2] ? dog_position == canoe_position :
              req[1] ? mouse_position == canoe_position : 1'b1;
    ones_nx = ones == 4'd9 ? 4'd0 : ones + 4'd1;
    tens_nx = ones != 4'd9 ? tens : tens == 4'd9 ? 4'd0 : tens + 4'd1;
    win_c = cat_position & dog_position & mouse_position;
    lose_c = cat_position != canoe_position &&
             (cat_position == dog_position || cat_position == mouse_position);
`ifdef MOVE_LIMIT_EN
    lose_c = lose_c || {tens, ones} == LIMIT;
`endif
  end
  always_ff @(posedge clk_1kHz or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      step <= '0;
      dir <= 1'b0;
      cat_position <= 1'b0;
      dog_position <= 1'b0;
      mouse_position <= 1'b0;
      canoe_position <= 1'b0;
      passenger <= '0;
      pass_col <= '0;
      cnt_canoe <= '0;
      ones <= '0;
      tens <= '0;
      gameState <= 2'd2;
      reject <= 1'b0;
    end else begin
      reject <= 1'b0;
      case (state)
        IDLE, WIN, LOSE: begin
          if (sw6 && clr) begin
            state <= IDLE;
            step <= '0;
            dir <= 1'b0;
            cat_position <= 1'b0;
            dog_position <= 1'b0;
            mouse_position <= 1'b0;
            canoe_position <= 1'b0;
            passenger <= '0;
            pass_col <= '0;
            cnt_canoe <= '0;
            ones <= '0;
            tens <= '0;
            gameState <= 2'd2;
          end else if (state == IDLE && sw6 && |req) begin
            if (pick_ok) begin
              passenger <= pick;
              dir <= ~canoe_position;
              step <= '0;
              state <= CROSS;
              gameState <= 2'd3;
            end else
              reject <= 1'b1;
          end
        end
        CROSS: if (tick_4Hz) begin
          step <= step_nx;
          // last tick lands the canoe: bar and column hold at the bank they reached
          if (step == LAST) begin
            canoe_position <= ~canoe_position;
            cat_position <= cat_position ^ passenger[2];
            dog_position <= dog_position ^ passenger[1];
            mouse_position <= mouse_position ^ passenger[0];
            passenger <= '0;
            ones <= ones_nx;
            tens <= tens_nx;
            state <= CHECK;
          end else begin
            cnt_canoe <= cnt_nx;
            if (|passenger) pass_col <= 2'(cnt_nx >> PASS_SHIFT);
          end
        end
        CHECK: begin
          state <= win_c ? WIN : lose_c ? LOSE : IDLE;
          gameState <= win_c ? 2'd1 : lose_c ? 2'd0 : 2'd2;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_crossing_scheduler.sv
// tb_crossing_scheduler: directed game scenarios plus random play checked against a bank/score model.
module tb_crossing_scheduler;
  logic clk_1kHz = 0, rst_n = 0, tick_4Hz = 0, sw6 = 0, clr = 0;
  logic [3:0] req = '0;
  logic cat_position, dog_position, mouse_position, canoe_position, reject;
  logic [2:0] passenger;
  logic [1:0] pass_col, gameState;
  logic [3:0] cnt_canoe, ones, tens;
  crossing_scheduler dut (
    .clk_1kHz(clk_1kHz), .rst_n(rst_n), .tick_4Hz(tick_4Hz), .sw6(sw6), .req(req), .clr(clr),
    .cat_position(cat_position), .dog_position(dog_position), .mouse_position(mouse_position),
    .canoe_position(canoe_position), .passenger(passenger), .pass_col(pass_col),
    .cnt_canoe(cnt_canoe), .ones(ones), .tens(tens), .gameState(gameState), .reject(reject)
  );
  always #5 clk_1kHz = ~clk_1kHz;
  localparam int MI = 0, MX = 1, MC = 2, MW = 3, ML = 4;
  int checks = 0, failures = 0;
  int pos[4];
  int moves, mode, ticks, rider, bar, col, rej;
  bit far;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 4; i++) pos[i] = 0;
    moves = 0; mode = MI; ticks = 0; rider = -1; bar = 0; col = 0; rej = 0; far = 0;
  endtask
  task automatic model_step(input logic [3:0] r, input logic c, input logic s, input logic t);
    int w;
    rej = 0;
    if (mode == MX) begin
      if (t) begin
        ticks++;
        if (ticks == 16) begin
          pos[3] = 1 - pos[3];
          if (rider >= 0) pos[rider] = 1 - pos[rider];
          rider = -1;
          moves = (moves + 1) % 100;
          mode = MC;
        end else begin
          bar = far ? ticks : 15 - ticks;
          if (rider >= 0) col = bar / 4;
        end
      end
    end else if (mode == MC) begin
      if (pos[0] && pos[1] && pos[2]) mode = MW;
      else if (pos[0] != pos[3] && (pos[0] == pos[1] || pos[0] == pos[2])) mode = ML;
`ifdef MOVE_LIMIT_EN
      else if (moves == 17) mode = ML;
`endif
      else mode = MI;
    end else if (s && c) model_reset();
    else if (mode == MI && s && r != 0) begin
      w = 3;
      for (int i = 0; i < 4; i++) if (r[i]) w = 3 - i;
      if (w < 3 && pos[w] != pos[3]) rej = 1;
      else begin
        mode = MX; rider = w < 3 ? w : -1; far = pos[3] == 0; ticks = 0;
      end
    end
  endtask
  task automatic compare_all();
    int gs;
    gs = mode == MI ? 2 : mode == MW ? 1 : mode == ML ? 0 : 3;
    chk("cat", cat_position, pos[0]);
    chk("dog", dog_position, pos[1]);
    chk("mouse", mouse_position, pos[2]);
    chk("canoe", canoe_position, pos[3]);
    chk("passenger", passenger, rider < 0 ? 0 : 4 >> rider);
    chk("pass_col", pass_col, col);
    chk("cnt_canoe", cnt_canoe, bar);
    chk("ones", ones, moves % 10);
    chk("tens", tens, moves / 10);
    chk("gameState", gameState, gs);
    chk("reject", reject, rej);
  endtask
  task automatic cyc(input logic [3:0] r, input logic c, input logic s, input logic t);
    req = r; clr = c; sw6 = s; tick_4Hz = t;
    @(posedge clk_1kHz);
    model_step(r, c, s, t);
    #1;
    compare_all();
    req = '0; clr = 0; tick_4Hz = 0;
  endtask
  task automatic run_ticks(input int n);
    repeat (n) cyc(4'b0000, 0, 1, 1);
  endtask
  task automatic go(input logic [3:0] r);
    cyc(r, 0, 1, 0);
    run_ticks(16);
    cyc(4'b0000, 0, 1, 0);
    cyc(4'b0000, 0, 1, 0);
  endtask
  initial begin
    logic [3:0] seq[7];
    model_reset();
    repeat (2) @(posedge clk_1kHz);
    #1;
    compare_all();
    chk("rst_gs", gameState, 2);
    rst_n = 1;
    cyc(4'b1000, 0, 1, 0);
    chk("accept_gs", gameState, 3);
    for (int k = 1; k < 16; k++) begin
      cyc(4'b0000, 0, 1, 1);
      chk("bar_step", cnt_canoe, k);
      chk("col_step", pass_col, k / 4);
    end
    run_ticks(1);
    cyc(4'b0000, 0, 1, 0);
    cyc(4'b0000, 0, 1, 0);
    chk("cat_far", cat_position, 1);
    chk("canoe_far", canoe_position, 1);
    chk("ones_1", ones, 1);
    chk("gs_idle", gameState, 2);
    cyc(4'b0010, 0, 1, 0);
    chk("reject_mouse", reject, 1);
    chk("mouse_stays", mouse_position, 0);
    cyc(4'b0000, 0, 1, 0);
    chk("reject_pulse", reject, 0);
    cyc(4'b0000, 1, 1, 0);
    go(4'b1110);
    chk("prio_cat", cat_position, 1);
    chk("prio_dog", dog_position, 0);
    chk("prio_mouse", mouse_position, 0);
    cyc(4'b0000, 1, 1, 0);
    go(4'b0100);
    chk("dog_lose", gameState, 0);
    cyc(4'b0100, 0, 1, 0);
    chk("lose_sticky", gameState, 0);
    cyc(4'b0000, 1, 1, 0);
    chk("clr_gs", gameState, 2);
    chk("clr_dog", dog_position, 0);
    chk("clr_ones", ones, 0);
    seq = '{4'b1000, 4'b0001, 4'b0010, 4'b1000, 4'b0100, 4'b0001, 4'b1000};
    foreach (seq[i]) go(seq[i]);
    chk("win_gs", gameState, 1);
    chk("win_ones", ones, 7);
    cyc(4'b1000, 0, 1, 0);
    run_ticks(3);
    chk("win_sticky", gameState, 1);
    chk("win_cat", cat_position, 1);
    cyc(4'b0000, 1, 1, 0);
    cyc(4'b1000, 0, 1, 0);
    run_ticks(4);
    cyc(4'b0000, 1, 1, 0);
    chk("clr_in_cross", gameState, 3);
    run_ticks(12);
    cyc(4'b0000, 0, 1, 0);
    cyc(4'b0000, 0, 1, 0);
    chk("cross_done_cat", cat_position, 1);
    chk("cross_done_ones", ones, 1);
    cyc(4'b0000, 1, 1, 0);
    cyc(4'b0100, 0, 1, 0);
    run_ticks(8);
    chk("mid_bar", cnt_canoe, 8);
    rst_n = 0;
    #1;
    chk("arst_bar", cnt_canoe, 0);
    chk("arst_pass", passenger, 0);
    chk("arst_gs", gameState, 2);
    model_reset();
    @(posedge clk_1kHz);
    #1;
    compare_all();
    rst_n = 1;
    for (int n = 0; n < 6000; n++)
      cyc($urandom_range(0, 5) == 0 ? 4'($urandom) : 4'b0000, $urandom_range(0, 79) == 0,
          $urandom_range(0, 15) != 0, $urandom_range(0, 3) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
